// File: rtl/sig_normalizer_pkg.sv
// Shared widths and constants for the adder-tree return path normalizer.
// Derived widths are exposed as functions so parameterized instances stay consistent.
package sig_normalizer_pkg;

   localparam int EXP_WIDTH_DEF  = 4;
   localparam int SIG_WIDTH_DEF  = 4;
   localparam int LOW_EXPAND_DEF = 2;

   function automatic int calc_sum_w(input int sig_w, input int low_exp);
      return sig_w + low_exp + 6;
   endfunction

   function automatic int calc_hp(input int sig_w, input int low_exp);
      return sig_w + low_exp;
   endfunction

   function automatic int calc_out_w(input int exp_w, input int sig_w);
      return 1 + exp_w + sig_w;
   endfunction

   localparam int SUM_W = calc_sum_w(SIG_WIDTH_DEF, LOW_EXPAND_DEF);
   localparam int HP    = calc_hp(SIG_WIDTH_DEF, LOW_EXPAND_DEF);
   localparam int OUT_W = calc_out_w(EXP_WIDTH_DEF, SIG_WIDTH_DEF);

   localparam logic [OUT_W-1:0] RES_ZERO    = '0;
   localparam logic [OUT_W-2:0] RES_SAT_MAG = '1;

endpackage

// File: rtl/sig_normalizer_lzc.sv
// Leading-one detector: reports the index of the highest set bit and a zero flag.
module sig_lzc #(
   parameter int W  = 12,
   parameter int PW = $clog2(W)
) (
   input  logic [W-1:0]  vec,
   output logic [PW-1:0] pos,
   output logic          zero
);

   // Scanning upward lets the highest set bit win.
   always_comb begin
      pos  = '0;
      zero = 1'b1;
      for (int i = 0; i < W; i++) begin
         if (vec[i]) begin
            pos  = PW'(i);
            zero = 1'b0;
         end
      end
   end

endmodule

// File: rtl/sig_normalizer.sv
// Converts two signed adder-tree sums into packed sign/exp/sig small floats
// through a 3-stage valid/ready pipeline (magnitude, normalize, round/pack).
module sig_normalizer
   import sig_normalizer_pkg::*;
#(
   parameter int expWidth   = EXP_WIDTH_DEF,
   parameter int sigWidth   = SIG_WIDTH_DEF,
   parameter int low_expand = LOW_EXPAND_DEF
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             in_valid,
   output logic                             in_ready,
   input  logic [sigWidth+low_expand+5:0]   sum1,
   input  logic [sigWidth+low_expand+5:0]   sum2,
   input  logic [expWidth-1:0]              max_exp,
   output logic                             out_valid,
   input  logic                             out_ready,
   output logic [expWidth+sigWidth:0]       res1,
   output logic [expWidth+sigWidth:0]       res2
);

   localparam int SW  = calc_sum_w(sigWidth, low_expand);
   localparam int HPL = calc_hp(sigWidth, low_expand);
   localparam int OW  = calc_out_w(expWidth, sigWidth);
   localparam int PW  = $clog2(SW);
   localparam int EW2 = expWidth + 2;

   localparam logic signed [EW2-1:0] E_ZERO = '0;
   localparam logic signed [EW2-1:0] E_MAX  = EW2'((1 << expWidth) - 1);

   logic                  en;
   logic [SW-1:0]         sum_in [2];

   logic                  s1_valid_q, s1_valid_d;
   logic [1:0]            s1_sign_q, s1_sign_d;
   logic [SW-1:0]         s1_mag_q [2];
   logic [SW-1:0]         s1_mag_d [2];
   logic [expWidth-1:0]   s1_exp_q, s1_exp_d;

   logic [PW-1:0]         lzc_pos [2];
   logic [1:0]            lzc_zero;
   logic [PW-1:0]         shamt [2];
   logic [SW-2:0]         frac [2];

   logic                  s2_valid_q, s2_valid_d;
   logic [1:0]            s2_sign_q, s2_sign_d;
   logic [1:0]            s2_zero_q, s2_zero_d;
   logic [sigWidth-1:0]   s2_mant_q [2];
   logic [sigWidth-1:0]   s2_mant_d [2];
   logic [1:0]            s2_guard_q, s2_guard_d;
   logic [1:0]            s2_sticky_q, s2_sticky_d;
   logic signed [EW2-1:0] s2_e_q [2];
   logic signed [EW2-1:0] s2_e_d [2];

   logic [1:0]            rnd;
   logic [sigWidth:0]     mant_rnd [2];
   logic signed [EW2-1:0] e_rnd [2];

   logic                  out_valid_q, out_valid_d;
   logic [OW-1:0]         res_q [2];
   logic [OW-1:0]         res_d [2];

   assign en        = out_ready | ~out_valid_q;
   assign in_ready  = en;
   assign sum_in[0] = sum1;
   assign sum_in[1] = sum2;
   assign out_valid = out_valid_q;
   assign res1      = res_q[0];
   assign res2      = res_q[1];

   // Stage 1: split sign and recover magnitude; the most negative sum maps cleanly to 2^(SW-1).
   always_comb begin
      s1_valid_d = s1_valid_q;
      s1_sign_d  = s1_sign_q;
      s1_exp_d   = s1_exp_q;
      for (int l = 0; l < 2; l++) begin
         s1_mag_d[l] = s1_mag_q[l];
      end
      if (en) begin
         s1_valid_d = in_valid;
         s1_exp_d   = max_exp;
         for (int l = 0; l < 2; l++) begin
            s1_sign_d[l] = sum_in[l][SW-1];
            s1_mag_d[l]  = sum_in[l][SW-1] ? (~sum_in[l] + SW'(1)) : sum_in[l];
         end
      end
   end

   for (genvar g = 0; g < 2; g++) begin : g_lzc
      sig_lzc #(.W(SW), .PW(PW)) u_lzc (
         .vec  (s1_mag_q[g]),
         .pos  (lzc_pos[g]),
         .zero (lzc_zero[g])
      );
   end

   // Stage 2: shift the leading one out of the top, keep mantissa, guard and sticky.
   always_comb begin
      s2_valid_d  = s2_valid_q;
      s2_sign_d   = s2_sign_q;
      s2_zero_d   = s2_zero_q;
      s2_guard_d  = s2_guard_q;
      s2_sticky_d = s2_sticky_q;
      for (int l = 0; l < 2; l++) begin
         shamt[l]     = PW'(SW - 1) - lzc_pos[l];
         frac[l]      = (SW-1)'(s1_mag_q[l] << shamt[l]);
         s2_mant_d[l] = s2_mant_q[l];
         s2_e_d[l]    = s2_e_q[l];
      end
      if (en) begin
         s2_valid_d = s1_valid_q;
         s2_sign_d  = s1_sign_q;
         s2_zero_d  = lzc_zero;
         for (int l = 0; l < 2; l++) begin
            s2_mant_d[l]   = frac[l][SW-2 -: sigWidth];
            s2_guard_d[l]  = frac[l][SW-2-sigWidth];
            s2_sticky_d[l] = |frac[l][SW-3-sigWidth:0];
            s2_e_d[l]      = EW2'(s1_exp_q) + EW2'(lzc_pos[l]) - EW2'(HPL);
         end
      end
   end

   // Stage 3: round to nearest even, then zero / underflow / saturation selection.
   always_comb begin
      out_valid_d = out_valid_q;
      if (en) begin
         out_valid_d = s2_valid_q;
      end
      for (int l = 0; l < 2; l++) begin
         rnd[l]      = s2_guard_q[l] & (s2_sticky_q[l] | s2_mant_q[l][0]);
         mant_rnd[l] = {1'b0, s2_mant_q[l]} + (sigWidth+1)'(rnd[l]);
         e_rnd[l]    = s2_e_q[l] + EW2'(mant_rnd[l][sigWidth]);
         res_d[l]    = res_q[l];
         if (en && s2_valid_q) begin
            if (s2_zero_q[l] || e_rnd[l] <= E_ZERO) begin
               res_d[l] = '0;
            end else if (e_rnd[l] > E_MAX) begin
               res_d[l] = {s2_sign_q[l], {(OW-1){1'b1}}};
            end else begin
               res_d[l] = {s2_sign_q[l], e_rnd[l][expWidth-1:0], mant_rnd[l][sigWidth-1:0]};
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_q  <= 1'b0;
         s1_sign_q   <= '0;
         s1_exp_q    <= '0;
         s2_valid_q  <= 1'b0;
         s2_sign_q   <= '0;
         s2_zero_q   <= '0;
         s2_guard_q  <= '0;
         s2_sticky_q <= '0;
         out_valid_q <= 1'b0;
         for (int l = 0; l < 2; l++) begin
            s1_mag_q[l]  <= '0;
            s2_mant_q[l] <= '0;
            s2_e_q[l]    <= '0;
            res_q[l]     <= '0;
         end
      end else begin
         s1_valid_q  <= s1_valid_d;
         s1_sign_q   <= s1_sign_d;
         s1_exp_q    <= s1_exp_d;
         s2_valid_q  <= s2_valid_d;
         s2_sign_q   <= s2_sign_d;
         s2_zero_q   <= s2_zero_d;
         s2_guard_q  <= s2_guard_d;
         s2_sticky_q <= s2_sticky_d;
         out_valid_q <= out_valid_d;
         for (int l = 0; l < 2; l++) begin
            s1_mag_q[l]  <= s1_mag_d[l];
            s2_mant_q[l] <= s2_mant_d[l];
            s2_e_q[l]    <= s2_e_d[l];
            res_q[l]     <= res_d[l];
         end
      end
   end

endmodule

// File: tb/tb_sig_normalizer.sv
// Directed self-checking bench for sig_normalizer at default widths
// (12-bit sums, 4-bit exponent, 9-bit packed results).
module tb_sig_normalizer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [11:0] sum1;
   logic [11:0] sum2;
   logic [3:0]  max_exp;
   logic        out_valid;
   logic        out_ready;
   logic [8:0]  res1;
   logic [8:0]  res2;

   int tests_run    = 0;
   int tests_failed = 0;

   logic [11:0] bp_s1 [8] = '{12'h040, 12'h0C0, 12'h000, 12'h020, 12'h0C0, 12'h041, 12'h043, 12'h042};
   logic [11:0] bp_s2 [8] = '{12'hFC0, 12'h07E, 12'h100, 12'h800, 12'hF40, 12'h044, 12'h046, 12'h100};
   logic [3:0]  bp_me [8] = '{4'd7, 4'd7, 4'd7, 4'd7, 4'd3, 4'd7, 4'd7, 4'd15};
   logic [8:0]  bp_e1 [8] = '{9'h070, 9'h088, 9'h000, 9'h060, 9'h048, 9'h070, 9'h071, 9'h0F0};
   logic [8:0]  bp_e2 [8] = '{9'h170, 9'h080, 9'h090, 9'h1C0, 9'h148, 9'h071, 9'h072, 9'h0FF};

   sig_normalizer dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .sum1      (sum1),
      .sum2      (sum2),
      .max_exp   (max_exp),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .res1      (res1),
      .res2      (res2)
   );

   always #5 clk = ~clk;

   // Presents one beat with out_ready high and waits (bounded) for its result.
   task automatic run_beat(input logic [11:0] a, input logic [11:0] b, input logic [3:0] me,
                           output logic [8:0] r1, output logic [8:0] r2, output int lat);
      @(negedge clk);
      in_valid  = 1'b1;
      sum1      = a;
      sum2      = b;
      max_exp   = me;
      out_ready = 1'b1;
      lat = -1;
      r1  = 'x;
      r2  = 'x;
      for (int c = 1; c <= 10; c++) begin
         @(negedge clk);
         in_valid = 1'b0;
         if (out_valid) begin
            lat = c;
            r1  = res1;
            r2  = res2;
            break;
         end
      end
   endtask

   task automatic test_reset;
      #1;
      tests_run++;
      if (out_valid !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid);
      end
      tests_run++;
      if (res1 !== 9'h000 || res2 !== 9'h000) begin
         tests_failed++;
         $display("[TB] FAIL reset_res: got %h/%h expected 000/000", res1, res2);
      end
      tests_run++;
      if (in_ready !== 1'b1) begin
         tests_failed++;
         $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready);
      end
   endtask

   task automatic test_basic;
      logic [8:0] r1, r2;
      int lat;
      run_beat(12'h040, 12'hFC0, 4'd7, r1, r2, lat);
      tests_run++;
      if (lat !== 3) begin
         tests_failed++;
         $display("[TB] FAIL basic_latency: got %0d expected 3", lat);
      end
      tests_run++;
      if (r1 !== 9'h070) begin
         tests_failed++;
         $display("[TB] FAIL basic_res1: got %h expected 070", r1);
      end
      tests_run++;
      if (r2 !== 9'h170) begin
         tests_failed++;
         $display("[TB] FAIL basic_res2_negative: got %h expected 170", r2);
      end
   endtask

   task automatic test_rounding;
      logic [8:0] r1, r2;
      int lat;
      run_beat(12'h0C0, 12'h07E, 4'd7, r1, r2, lat);
      tests_run++;
      if (r1 !== 9'h088) begin
         tests_failed++;
         $display("[TB] FAIL norm_p7: got %h expected 088", r1);
      end
      tests_run++;
      if (r2 !== 9'h080) begin
         tests_failed++;
         $display("[TB] FAIL rne_carry: got %h expected 080", r2);
      end
      run_beat(12'h042, 12'h046, 4'd7, r1, r2, lat);
      tests_run++;
      if (r1 !== 9'h070) begin
         tests_failed++;
         $display("[TB] FAIL rne_tie_even_down: got %h expected 070", r1);
      end
      tests_run++;
      if (r2 !== 9'h072) begin
         tests_failed++;
         $display("[TB] FAIL rne_tie_odd_up: got %h expected 072", r2);
      end
      run_beat(12'h043, 12'h041, 4'd7, r1, r2, lat);
      tests_run++;
      if (r1 !== 9'h071 || r2 !== 9'h070) begin
         tests_failed++;
         $display("[TB] FAIL rne_sticky: got %h/%h expected 071/070", r1, r2);
      end
   endtask

   task automatic test_boundaries;
      logic [8:0] r1, r2;
      int lat;
      run_beat(12'h000, 12'h020, 4'd0, r1, r2, lat);
      tests_run++;
      if (r1 !== 9'h000) begin
         tests_failed++;
         $display("[TB] FAIL zero_sum: got %h expected 000", r1);
      end
      tests_run++;
      if (r2 !== 9'h000) begin
         tests_failed++;
         $display("[TB] FAIL underflow: got %h expected 000", r2);
      end
      run_beat(12'h100, 12'h800, 4'd15, r1, r2, lat);
      tests_run++;
      if (r1 !== 9'h0FF) begin
         tests_failed++;
         $display("[TB] FAIL saturate_pos: got %h expected 0FF", r1);
      end
      tests_run++;
      if (r2 !== 9'h1FF) begin
         tests_failed++;
         $display("[TB] FAIL saturate_most_neg: got %h expected 1FF", r2);
      end
   endtask

   task automatic test_backpressure;
      int tx = 0;
      int rx = 0;
      for (int cyc = 0; cyc < 300 && rx < 8; cyc++) begin
         @(negedge clk);
         out_ready = 1'($urandom_range(0, 1));
         if (tx < 8) begin
            in_valid = 1'b1;
            sum1     = bp_s1[tx];
            sum2     = bp_s2[tx];
            max_exp  = bp_me[tx];
         end else begin
            in_valid = 1'b0;
         end
         #1;
         tests_run++;
         if (in_ready !== !(out_valid && !out_ready)) begin
            tests_failed++;
            $display("[TB] FAIL bp_in_ready: got %b expected %b", in_ready, !(out_valid && !out_ready));
         end
         if (out_valid && out_ready) begin
            tests_run++;
            if (rx >= 8 || res1 !== bp_e1[rx] || res2 !== bp_e2[rx]) begin
               tests_failed++;
               $display("[TB] FAIL bp_result_%0d: got %h/%h expected %h/%h", rx, res1, res2,
                        bp_e1[rx % 8], bp_e2[rx % 8]);
            end
            rx++;
         end
         if (in_valid && in_ready) tx++;
      end
      @(negedge clk);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      tests_run++;
      if (rx != 8) begin
         tests_failed++;
         $display("[TB] FAIL bp_count: got %0d results expected 8", rx);
      end
      repeat (4) @(negedge clk);
   endtask

   task automatic test_reset_flight;
      logic seen_valid = 1'b0;
      out_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         in_valid = 1'b1;
         sum1     = 12'h040;
         sum2     = 12'h0C0;
         max_exp  = 4'd7;
      end
      @(negedge clk);
      in_valid = 1'b0;
      rst_n    = 1'b0;
      #1;
      tests_run++;
      if (out_valid !== 1'b0 || res1 !== 9'h000 || res2 !== 9'h000) begin
         tests_failed++;
         $display("[TB] FAIL flight_reset: got valid=%b res=%h/%h expected 0 000/000", out_valid, res1, res2);
      end
      @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         if (out_valid) seen_valid = 1'b1;
      end
      tests_run++;
      if (seen_valid !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL flight_stale: got out_valid after reset expected none");
      end
      tests_run++;
      if (in_ready !== 1'b1) begin
         tests_failed++;
         $display("[TB] FAIL flight_in_ready: got %b expected 1", in_ready);
      end
   endtask

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      sum1      = '0;
      sum2      = '0;
      max_exp   = '0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      test_reset();
      test_basic();
      test_rounding();
      test_boundaries();
      test_backpressure();
      test_reset_flight();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
